// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal keypad entry encoder.
package decimal_entry_pkg;

  typedef enum logic {
    ENTRY   = 1'b0,
    CONVERT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_OFF = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int unsigned DIGITS_DEF = 8;
  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned COUNT_W    = 4;

  // Blank (OFF) nibbles contribute zero to the converted value.
  function automatic logic [3:0] bcd_digit(input logic [3:0] n);
    return (n == BCD_OFF) ? 4'd0 : n;
  endfunction

endpackage

// File: rtl/times_ten_add.sv
// One Horner step: y = acc*10 + d, truncated to WIDTH bits.
module times_ten_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] y
);

  assign y = (acc << 3) + (acc << 1) + WIDTH'(d);

endmodule

// File: rtl/decimal_entry_encoder.sv
// Collects BCD digits MSD first and converts the entry to binary over DIGITS cycles.
module decimal_entry_encoder
  import decimal_entry_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  backspace,
  input  logic                  clear,
  input  logic                  commit,
  output logic                  ready,
  output logic [COUNT_W-1:0]    count,
  output logic [DIGITS*4-1:0]   entry_bcd,
  output logic [WIDTH-1:0]      number,
  output logic                  number_valid,
  output logic                  entry_error
);

  localparam int unsigned BW = DIGITS * 4;

  state_e               state_q, state_d;
  logic [BW-1:0]        buf_q, buf_d;
  logic [BW-1:0]        conv_q, conv_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     number_q, number_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     horner_y;

  // Conversion consumes the top nibble of the captured buffer each step.
  times_ten_add #(.WIDTH(WIDTH)) u_times_ten_add (
    .acc (acc_q),
    .d   (conv_q[BW-1 -: 4]),
    .y   (horner_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ENTRY;
      buf_q    <= {DIGITS{BCD_OFF}};
      conv_q   <= '0;
      count_q  <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      conv_q   <= conv_d;
      count_q  <= count_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    conv_d   = conv_q;
    count_d  = count_q;
    step_d   = step_q;
    acc_d    = acc_q;
    number_d = number_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ENTRY: begin
        // One action per cycle: clear > commit > backspace > digit.
        if (clear) begin
          buf_d   = {DIGITS{BCD_OFF}};
          count_d = '0;
        end else if (commit) begin
          for (int i = 0; i < DIGITS; i++) begin
            conv_d[i*4 +: 4] = bcd_digit(buf_q[i*4 +: 4]);
          end
          acc_d   = '0;
          step_d  = '0;
          state_d = CONVERT;
        end else if (backspace) begin
          if (count_q != '0) begin
            buf_d   = {BCD_OFF, buf_q[BW-1:4]};
            count_d = count_q - COUNT_W'(1);
          end
        end else if (digit_valid) begin
          if ((digit <= BCD_MAX) && (count_q < COUNT_W'(DIGITS))) begin
            buf_d   = {buf_q[BW-5:0], digit};
            count_d = count_q + COUNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CONVERT: begin
        acc_d  = horner_y;
        conv_d = {conv_q[BW-5:0], 4'h0};
        step_d = step_q + COUNT_W'(1);
        if (step_q == COUNT_W'(DIGITS - 1)) begin
          number_d = horner_y;
          valid_d  = 1'b1;
          buf_d    = {DIGITS{BCD_OFF}};
          count_d  = '0;
          step_d   = '0;
          state_d  = ENTRY;
        end
      end

      default: state_d = ENTRY;
    endcase
  end

  assign ready        = (state_q == ENTRY);
  assign count        = count_q;
  assign entry_bcd    = buf_q;
  assign number       = number_q;
  assign number_valid = valid_q;
  assign entry_error  = err_q;

endmodule

// File: tb/tb_decimal_entry_encoder.sv
// Scoreboard bench for decimal_entry_encoder with a digit-list reference model.
module tb_decimal_entry_encoder;

  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        digit_valid, backspace, clear, commit;
  logic [3:0]  digit;
  logic        ready;
  logic [3:0]  count;
  logic [31:0] entry_bcd;
  logic [31:0] number;
  logic        number_valid, entry_error;

  decimal_entry_encoder #(.DIGITS(8), .WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .backspace    (backspace),
    .clear        (clear),
    .commit       (commit),
    .ready        (ready),
    .count        (count),
    .entry_bcd    (entry_bcd),
    .number       (number),
    .number_valid (number_valid),
    .entry_error  (entry_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          model_q[$];
  exp_t        sb[$];
  logic [31:0] last_num = 32'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_bcd();
    logic [31:0] r;
    r = '1;
    for (int i = 0; i < model_q.size(); i++) r[i*4 +: 4] = 4'(model_q[model_q.size()-1-i]);
    return r;
  endfunction

  function automatic logic [31:0] model_value();
    longint n, p;
    n = 0;
    p = 1;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      n += longint'(model_q[i]) * p;
      p *= 10;
    end
    return 32'(n);
  endfunction

  // Monitor: every valid pulse must match the oldest pending commit.
  always @(negedge clk) begin
    if (number_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_valid: number 0x%h with no pending commit", number);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("number", number, e.val);
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic finish_convert(input logic [31:0] exp_val);
    bit done;
    for (int k = 0; k < DIGITS - 2; k++) begin
      clear       = 1'($urandom);
      commit      = 1'($urandom);
      backspace   = 1'($urandom);
      digit_valid = 1'($urandom);
      digit       = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("conv_ready", 32'(ready), 32'd0);
      check("conv_error", 32'(entry_error), 32'd0);
      check("conv_count", 32'(count), 32'(model_q.size()));
      check("conv_bcd", entry_bcd, model_bcd());
    end
    clear = 0; commit = 0; backspace = 0; digit_valid = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      if (ready) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL convert_timeout: ready 0 expected 1");
    end
    check("done_valid", 32'(number_valid), 32'd1);
    check("done_number", number, exp_val);
    model_q.delete();
    check("done_count", 32'(count), 32'd0);
    check("done_bcd", entry_bcd, 32'hFFFF_FFFF);
    last_num = exp_val;
  endtask

  task automatic step(input logic cl, input logic cm, input logic bs, input logic dv,
                      input logic [3:0] d);
    bit          exp_err;
    bit          started;
    logic [31:0] exp_val;
    clear = cl; commit = cm; backspace = bs; digit_valid = dv; digit = d;
    @(posedge clk); #1;
    clear = 0; commit = 0; backspace = 0; digit_valid = 0;
    exp_err = 0;
    started = 0;
    exp_val = 32'd0;
    if (cl) model_q.delete();
    else if (cm) begin
      started = 1;
      exp_val = model_value();
      sb.push_back('{val: exp_val, due: cyc + DIGITS});
    end else if (bs) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
    end else if (dv) begin
      if (d <= 4'd9 && model_q.size() < DIGITS) model_q.push_back(int'(d));
      else exp_err = 1;
    end
    check("entry_error", 32'(entry_error), 32'(exp_err));
    check("count", 32'(count), 32'(model_q.size()));
    check("entry_bcd", entry_bcd, model_bcd());
    check("ready", 32'(ready), started ? 32'd0 : 32'd1);
    check("number_hold", number, last_num);
    if (started) finish_convert(exp_val);
  endtask

  task automatic key(input int d);
    step(0, 0, 0, 1, 4'(d));
  endtask

  initial begin
    reset = 1; clear = 0; commit = 0; backspace = 0; digit_valid = 0; digit = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_bcd", entry_bcd, 32'hFFFF_FFFF);
    check("rst_number", number, 32'd0);
    check("rst_valid", 32'(number_valid), 32'd0);
    check("rst_error", 32'(entry_error), 32'd0);
    reset = 0;
    @(posedge clk); #1;
    check("rst_ready", 32'(ready), 32'd1);

    for (int i = 1; i <= 8; i++) key(i);
    check("bcd_12345678", entry_bcd, 32'h1234_5678);
    step(0, 1, 0, 0, 4'd0);
    check("num_12345678", number, 32'h00BC_614E);

    for (int i = 0; i < 9; i++) key(9);
    step(0, 1, 0, 0, 4'd0);
    check("num_99999999", number, 32'd99999999);

    key(4); key(2); key(7);
    step(0, 0, 1, 0, 4'd0);
    key(1);
    step(0, 1, 0, 0, 4'd0);
    check("num_421", number, 32'd421);
    step(0, 0, 1, 0, 4'd0);

    key(3);
    step(0, 0, 0, 1, 4'hA);
    step(1, 0, 0, 1, 4'd5);
    step(0, 1, 1, 1, 4'd2);
    check("num_empty", number, 32'd0);

    key(0); key(0); key(7);
    step(0, 1, 0, 0, 4'd0);
    check("num_007", number, 32'd7);

    // Reset in the middle of a conversion aborts it silently.
    key(5); key(5);
    commit = 1;
    @(posedge clk); #1;
    commit = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1;
    #1;
    model_q.delete();
    sb.delete();
    last_num = 32'd0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_count", 32'(count), 32'd0);
    check("abort_bcd", entry_bcd, 32'hFFFF_FFFF);
    check("abort_number", number, 32'd0);
    check("abort_valid", 32'(number_valid), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_number_hold", number, 32'd0);
    key(3);
    step(0, 1, 0, 0, 4'd0);
    check("num_3", number, 32'd3);

    for (int n = 0; n < 300; n++) begin
      int a;
      a = $urandom_range(0, 99);
      if (a < 3) a = 0;
      else if (a < 9) a = 1;
      else if (a < 25) a = 2;
      else a = 3;
      step(a == 0,
           a == 1 || (a < 1 && 1'($urandom)),
           a == 2 || (a < 2 && 1'($urandom)),
           a == 3 || (a < 3 && 1'($urandom)),
           4'($urandom_range(0, 11)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
